// File: rtl/gate_rr_scheduler.sv
// Round-robin front end for one shared registered 2-input logic unit:
// arbitrates requesters, issues operands, and returns a tagged response.
module gate_rr_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_a,
  input  logic [NREQ-1:0]   req_b,
  input  logic [3*NREQ-1:0] req_fn,
  output logic [NREQ-1:0]   gnt,
  output logic              gu_a,
  output logic              gu_b,
  output logic [2:0]        gu_fn,
  input  logic              gu_y,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_y,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cur_id;
  logic           cur_err;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic           sel_a, sel_b;
  logic [2:0]     sel_fn;
  int unsigned    idx;

  // Search starts at ptr and wraps modulo NREQ, so NREQ need not be a power of 2.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_a  = 1'b0;
    sel_b  = 1'b0;
    sel_fn = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        sel_a  = req_a[i];
        sel_b  = req_b[i];
        sel_fn = req_fn[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are loaded one edge ahead of the state they belong to, so every port is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      cur_id    <= '0;
      cur_err   <= 1'b0;
      gnt       <= '0;
      gu_a      <= 1'b0;
      gu_b      <= 1'b0;
      gu_fn     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            cur_id  <= win_id;
            cur_err <= (sel_fn == 3'b111);
            gnt     <= NREQ'(1) << win_id;
            gu_a    <= sel_a;
            gu_b    <= sel_b;
            gu_fn   <= (sel_fn == 3'b111) ? 3'b000 : sel_fn;
            busy    <= 1'b1;
          end
        end
        ISSUE: begin
          if (cur_id == IDW'(NREQ - 1)) ptr <= '0;
          else                          ptr <= cur_id + 1'b1;
        end
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
          rsp_err   <= cur_err;
          rsp_y     <= cur_err ? 1'b0 : gu_y;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_rr_scheduler.sv
// Scoreboard bench for gate_rr_scheduler with a behavioural shared logic unit.
module tb_gate_rr_scheduler;

  logic        clk, rst;
  logic [3:0]  req, req_a, req_b;
  logic [11:0] req_fn;
  logic [3:0]  gnt;
  logic        gu_a, gu_b, gu_y;
  logic [2:0]  gu_fn;
  logic        rsp_valid, rsp_y, rsp_err, busy;
  logic [1:0]  rsp_id;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic [2:0] fn;
    logic       a, b, y, err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, prev_gnt_cyc = -1, last_gnt_cyc = 0;
  bit   b2b = 0;

  gate_rr_scheduler #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_fn(req_fn),
    .gnt(gnt), .gu_a(gu_a), .gu_b(gu_b), .gu_fn(gu_fn), .gu_y(gu_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic lu(input logic [2:0] fn, input logic a, input logic b);
    case (fn)
      3'd0: lu = a & b;
      3'd1: lu = a | b;
      3'd2: lu = a ^ b;
      3'd3: lu = ~(a & b);
      3'd4: lu = ~(a | b);
      3'd5: lu = ~(a ^ b);
      3'd6: lu = ~a;
      default: lu = 1'b0;
    endcase
  endfunction

  always @(posedge clk) gu_y <= lu(gu_fn, gu_a, gu_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic a, input logic b, input logic [2:0] fn);
    exp_t e;
    e.gnt = 4'(1) << id;
    e.id  = 2'(id);
    e.err = (fn == 3'b111);
    e.fn  = e.err ? 3'b000 : fn;
    e.a   = a;
    e.b   = b;
    e.y   = e.err ? 1'b0 : lu(fn, a, b);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != 0) begin
        if (q.size() == 0) chk("spurious_gnt", 32'(gnt), 0);
        else begin
          chk("gnt", 32'(gnt), 32'(q[0].gnt));
          chk("gu_fn", 32'(gu_fn), 32'(q[0].fn));
          chk("gu_a", 32'(gu_a), 32'(q[0].a));
          chk("gu_b", 32'(gu_b), 32'(q[0].b));
          chk("busy_issue", 32'(busy), 1);
        end
        if (b2b && prev_gnt_cyc >= 0) chk("gnt_gap", 32'(cyc - prev_gnt_cyc), 3);
        prev_gnt_cyc = cyc;
        last_gnt_cyc = cyc;
      end
      if (rsp_valid) begin
        if (q.size() == 0) chk("spurious_rsp", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_y", 32'(rsp_y), 32'(e.y));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_lat", 32'(cyc - last_gnt_cyc), 2);
          chk("busy_rsp", 32'(busy), 0);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_gnts(input int cnt);
    int seen = 0, n = 0;
    while (seen < cnt && n < 20 * cnt) begin
      @(negedge clk);
      n++;
      if (gnt != 0) seen++;
    end
    if (seen < cnt) chk("gnt_timeout", 32'(seen), 32'(cnt));
  endtask

  task automatic single_op(input int r, input logic a, input logic b, input logic [2:0] fn);
    int n = 0;
    wait_idle();
    req_a[r] = a;
    req_b[r] = b;
    req_fn[3*r +: 3] = fn;
    push_exp(r, a, b, fn);
    req = 4'(1) << r;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 0 && n < 10);
    chk("gnt_lat", 32'(n), 1);
    req = '0;
  endtask

  initial begin
    rst = 1; req = 4'b1111;
    req_a = 4'b0101; req_b = 4'b0011;
    req_fn = {3'd5, 3'd2, 3'd1, 3'd0};
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_gu", 32'({gu_a, gu_b, gu_fn}), 0);
    chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_y, rsp_err}), 0);
    chk("rst_busy", 32'(busy), 0);

    // round robin from reset, request held continuously
    foreach (q[i]) ;
    for (int i = 0; i < 6; i++) push_exp(i % 4, req_a[i % 4], req_b[i % 4], req_fn[3*(i % 4) +: 3]);
    prev_gnt_cyc = -1; b2b = 1;
    rst = 0;
    wait_gnts(6);
    req = '0;
    wait_idle();
    b2b = 0;

    // skip and wrap from reset, then a lone req0 right after the grant to 3
    rst = 1;
    @(negedge clk);
    push_exp(1, req_a[1], req_b[1], req_fn[5:3]);
    push_exp(3, req_a[3], req_b[3], req_fn[11:9]);
    push_exp(1, req_a[1], req_b[1], req_fn[5:3]);
    push_exp(3, req_a[3], req_b[3], req_fn[11:9]);
    push_exp(0, req_a[0], req_b[0], req_fn[2:0]);
    prev_gnt_cyc = -1; b2b = 1;
    req = 4'b1010;
    rst = 0;
    wait_gnts(4);
    req = 4'b0001;
    wait_gnts(1);
    req = '0;
    wait_idle();
    b2b = 0;

    // single operations across the truth table
    single_op(2, 1'b1, 1'b0, 3'b001);
    for (int f = 0; f < 7; f++)
      for (int ab = 0; ab < 4; ab++)
        single_op((f + ab) % 4, ab[1], ab[0], 3'(f));

    // illegal code followed immediately by a legal one on the same requester
    wait_idle();
    req_a[0] = 1; req_b[0] = 1; req_fn[2:0] = 3'b111;
    push_exp(0, 1'b1, 1'b1, 3'b111);
    push_exp(0, 1'b1, 1'b1, 3'b000);
    req = 4'b0001;
    wait_gnts(1);
    req_fn[2:0] = 3'b000;
    wait_gnts(1);
    req = '0;
    wait_idle();

    // reset during CAPTURE discards the operation and clears the pointer
    req_a[1] = 0; req_b[1] = 1; req_fn[5:3] = 3'd2;
    push_exp(0, 1'b1, 1'b1, 3'b000);
    req = 4'b0001;
    wait_gnts(1);
    req = '0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_rsp", 32'(rsp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_gnt", 32'(gnt), 0);
    q.delete();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_rsp", 32'(rsp_valid), 0);
    end
    push_exp(0, 1'b1, 1'b1, 3'b000);
    push_exp(1, 1'b0, 1'b1, 3'd2);
    req = 4'b0011;
    wait_gnts(1);
    req = 4'b0010;
    wait_gnts(1);
    req = '0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
